// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer: issues req/ack fetches,
// advances or redirects the PC, and latches a sticky trap on misaligned redirects.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCTarget,
    input  logic        PCSrc,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    output logic        Misaligned,
    output logic [31:0] TrapPC
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2,
        TRAP = 2'd3
    } state_t;

    // The low two bits of the reset vector are dropped so the PC is always word aligned.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] trap_pc_q, trap_pc_d;

    logic [31:0] pc_plus4;
    logic        target_aligned;

    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = (PCTarget[1:0] == 2'b00);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        trap_pc_d    = trap_pc_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Stall wins over any redirect; alignment is only judged on a taken redirect.
                if (!Stall) begin
                    if (!PCSrc) begin
                        pc_d    = pc_plus4;
                        state_d = REQ;
                    end else if (target_aligned) begin
                        pc_d    = PCTarget;
                        state_d = REQ;
                    end else begin
                        trap_pc_d    = PCTarget;
                        misaligned_d = 1'b1;
                        state_d      = TRAP;
                    end
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC_ALIGNED;
            misaligned_q <= 1'b0;
            trap_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            trap_pc_q    <= trap_pc_d;
        end
    end

    assign imem_req   = (state_q == REQ);
    assign InstrValid = (state_q == EXEC);
    assign imem_addr  = pc_q;
    assign PC         = pc_q;
    assign PCPlus4    = pc_plus4;
    assign Misaligned = misaligned_q;
    assign TrapPC     = trap_pc_q;

endmodule
